// File: rtl/tap_controller_pkg.sv
// JTAG TAP shared types: state codes, strobe bundle,
// instruction codes and the TMS transition function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR      = 4'hF,
        RTI      = 4'hC,
        SEL_DR   = 4'h7,
        CAP_DR   = 4'h6,
        SH_DR    = 4'h2,
        EX1_DR   = 4'h1,
        PAUSE_DR = 4'h3,
        EX2_DR   = 4'h0,
        UPD_DR   = 4'h5,
        SEL_IR   = 4'h4,
        CAP_IR   = 4'hE,
        SH_IR    = 4'hA,
        EX1_IR   = 4'h9,
        PAUSE_IR = 4'hB,
        EX2_IR   = 4'h8,
        UPD_IR   = 4'hD
    } tap_state_t;

    typedef struct packed {
        logic tlr;
        logic cap_dr;
        logic sh_dr;
        logic upd_dr;
        logic cap_ir;
        logic sh_ir;
        logic upd_ir;
    } tap_strobe_t;

    localparam tap_strobe_t STROBE_RST = '{tlr: 1'b1, default: 1'b0};

    localparam logic [3:0] IDCODE_CODE = 4'b0001;
    localparam logic [3:0] EXTEST_CODE = 4'b0000;
    localparam logic [3:0] SAMPLE_CODE = 4'b0010;

    function automatic tap_state_t next_state(
        input tap_state_t s,
        input logic       tms
    );
        tap_state_t n;
        n = TLR;
        unique case (s)
            TLR:      n = tms ? TLR    : RTI;
            RTI:      n = tms ? SEL_DR : RTI;
            SEL_DR:   n = tms ? SEL_IR : CAP_DR;
            CAP_DR:   n = tms ? EX1_DR : SH_DR;
            SH_DR:    n = tms ? EX1_DR : SH_DR;
            EX1_DR:   n = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: n = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   n = tms ? UPD_DR : SH_DR;
            UPD_DR:   n = tms ? SEL_DR : RTI;
            SEL_IR:   n = tms ? TLR    : CAP_IR;
            CAP_IR:   n = tms ? EX1_IR : SH_IR;
            SH_IR:    n = tms ? EX1_IR : SH_IR;
            EX1_IR:   n = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: n = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   n = tms ? UPD_IR : SH_IR;
            UPD_IR:   n = tms ? SEL_DR : RTI;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP pin and control-bundle interface; the master side
// drives the serial inputs, the controller is the slave.
interface tap_controller_if #(
    parameter int IR_WIDTH = 4
);
    logic                tms;
    logic                tdi;
    logic                dr_tdo;
    logic                tdo;
    logic                tdo_en;
    logic [3:0]          state;
    logic                test_logic_reset;
    logic                capture_dr;
    logic                shift_dr;
    logic                update_dr;
    logic                capture_ir;
    logic                shift_ir;
    logic                update_ir;
    logic [IR_WIDTH-1:0] instr;
    logic                mode;
    logic                bypass_sel;

    modport master (
        output tms, tdi, dr_tdo,
        input  tdo, tdo_en, state, test_logic_reset,
        input  capture_dr, shift_dr, update_dr,
        input  capture_ir, shift_ir, update_ir,
        input  instr, mode, bypass_sel
    );

    modport slave (
        input  tms, tdi, dr_tdo,
        output tdo, tdo_en, state, test_logic_reset,
        output capture_dr, shift_dr, update_dr,
        output capture_ir, shift_ir, update_ir,
        output instr, mode, bypass_sel
    );
endinterface

// File: rtl/tap_controller_fsm.sv
// 16-state TAP FSM with strobes registered from the
// next-state decode so they track state without glitches.
module tap_fsm
    import jtag_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tms,
    output tap_state_t  state,
    output tap_state_t  state_nxt,
    output tap_strobe_t strb
);

    tap_strobe_t strb_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
            strb  <= STROBE_RST;
        end else begin
            state <= state_nxt;
            strb  <= strb_nxt;
        end
    end

    always_comb begin
        state_nxt = next_state(state, tms);
    end

    always_comb begin
        strb_nxt        = '0;
        strb_nxt.tlr    = (state_nxt == TLR);
        strb_nxt.cap_dr = (state_nxt == CAP_DR);
        strb_nxt.sh_dr  = (state_nxt == SH_DR);
        strb_nxt.upd_dr = (state_nxt == UPD_DR);
        strb_nxt.cap_ir = (state_nxt == CAP_IR);
        strb_nxt.sh_ir  = (state_nxt == SH_IR);
        strb_nxt.upd_ir = (state_nxt == UPD_IR);
    end

endmodule

// File: rtl/tap_controller.sv
// TAP controller top: FSM, instruction register, decoded
// instruction flags and the TDO mux.
module tap_controller
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(IDCODE_CODE),
    parameter logic [IR_WIDTH-1:0] EXTEST_INSTR = IR_WIDTH'(EXTEST_CODE),
    parameter logic [IR_WIDTH-1:0] SAMPLE_INSTR = IR_WIDTH'(SAMPLE_CODE),
    parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = '1
) (
    input  logic              clk,
    input  logic              rst_n,
    tap_controller_if.slave   bus
);

    tap_state_t          state;
    tap_state_t          state_nxt;
    tap_strobe_t         strb;
    logic [IR_WIDTH-1:0] ir_shift;
    logic [IR_WIDTH-1:0] instr;
    logic [IR_WIDTH-1:0] instr_d;
    logic                mode;
    logic                bypass_sel;
    logic                tdo;

    function automatic logic is_bypass(input logic [IR_WIDTH-1:0] i);
        return (i == BYPASS_INSTR) ||
               !((i == IDCODE_INSTR) ||
                 (i == EXTEST_INSTR) ||
                 (i == SAMPLE_INSTR));
    endfunction

    tap_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .tms       (bus.tms),
        .state     (state),
        .state_nxt (state_nxt),
        .strb      (strb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift <= '0;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_WIDTH'(2'b01);
        end else if (state == SH_IR) begin
            ir_shift <= {bus.tdi, ir_shift[IR_WIDTH-1:1]};
        end
    end

    // flags are registered with instr so they move only with it
    always_comb begin
        instr_d = instr;
        if (state_nxt == TLR) begin
            instr_d = IDCODE_INSTR;
        end else if (state == UPD_IR) begin
            instr_d = ir_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr      <= IDCODE_INSTR;
            mode       <= (IDCODE_INSTR == EXTEST_INSTR);
            bypass_sel <= is_bypass(IDCODE_INSTR);
        end else begin
            instr      <= instr_d;
            mode       <= (instr_d == EXTEST_INSTR);
            bypass_sel <= is_bypass(instr_d);
        end
    end

    always_comb begin
        tdo = 1'b0;
        unique case (1'b1)
            strb.sh_ir: tdo = ir_shift[0];
            strb.sh_dr: tdo = bus.dr_tdo;
            default:    tdo = 1'b0;
        endcase
    end

    assign bus.tdo              = tdo;
    assign bus.tdo_en           = strb.sh_ir | strb.sh_dr;
    assign bus.state            = state;
    assign bus.test_logic_reset = strb.tlr;
    assign bus.capture_dr       = strb.cap_dr;
    assign bus.shift_dr         = strb.sh_dr;
    assign bus.update_dr        = strb.upd_dr;
    assign bus.capture_ir       = strb.cap_ir;
    assign bus.shift_ir         = strb.sh_ir;
    assign bus.update_ir        = strb.upd_ir;
    assign bus.instr            = instr;
    assign bus.mode             = mode;
    assign bus.bypass_sel       = bypass_sel;

endmodule

// File: tb/tb_tap_controller.sv
// Directed bench for tap_controller: state walk, IR load,
// forced reset, pause/resume and instruction decode.
module tb_tap_controller;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   sdr_cnt;
    int   udr_cnt;

    tap_controller_if #(.IR_WIDTH(4)) bus ();

    tap_controller #(.IR_WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        sdr_cnt = 0;
        udr_cnt = 0;
    end

    always @(posedge clk) begin
        if (bus.shift_dr)  sdr_cnt <= sdr_cnt + 1;
        if (bus.update_dr) udr_cnt <= udr_cnt + 1;
    end

    task automatic step(input logic t, input logic d);
        bus.tms = t;
        bus.tdi = d;
        @(posedge clk);
        #1;
    endtask

    task automatic load_ir(input logic [3:0] v);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(i == 3, v[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'hF) begin
            failures++;
            $display("FAIL rst_state got=%h exp=%h", bus.state, 4'hF);
        end
        checks++;
        if (bus.test_logic_reset !== 1'b1) begin
            failures++;
            $display("FAIL rst_tlr got=%b exp=1", bus.test_logic_reset);
        end
        checks++;
        if (bus.instr !== 4'b0001 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL rst_instr got=%b/%b exp=0001/0", bus.instr, bus.mode);
        end
        checks++;
        if ({bus.capture_dr, bus.shift_dr, bus.update_dr,
             bus.capture_ir, bus.shift_ir, bus.update_ir,
             bus.tdo, bus.tdo_en} !== 8'h00) begin
            failures++;
            $display("FAIL rst_strobes got=%b%b%b%b%b%b%b%b exp=0",
                     bus.capture_dr, bus.shift_dr, bus.update_dr,
                     bus.capture_ir, bus.shift_ir, bus.update_ir,
                     bus.tdo, bus.tdo_en);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'hC || bus.test_logic_reset !== 1'b0) begin
            failures++;
            $display("FAIL rst_to_rti got=%h/%b exp=c/0", bus.state, bus.test_logic_reset);
        end
    endtask

    task automatic test_state_walk;
        bus.dr_tdo = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h7 || bus.shift_dr !== 1'b0 || bus.tdo_en !== 1'b0) begin
            failures++;
            $display("FAIL walk_seldr got=%h/%b/%b exp=7/0/0", bus.state, bus.shift_dr, bus.tdo_en);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'h6 || bus.capture_dr !== 1'b1 || bus.tdo_en !== 1'b0) begin
            failures++;
            $display("FAIL walk_capdr got=%h/%b/%b exp=6/1/0", bus.state, bus.capture_dr, bus.tdo_en);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'h2 || bus.shift_dr !== 1'b1 ||
            bus.tdo_en !== 1'b1 || bus.capture_dr !== 1'b0) begin
            failures++;
            $display("FAIL walk_shdr got=%h/%b/%b exp=2/1/1", bus.state, bus.shift_dr, bus.tdo_en);
        end
        checks++;
        if (bus.tdo !== 1'b1) begin
            failures++;
            $display("FAIL walk_tdo_dr got=%b exp=1", bus.tdo);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h1 || bus.shift_dr !== 1'b0 || bus.tdo !== 1'b0) begin
            failures++;
            $display("FAIL walk_ex1dr got=%h/%b/%b exp=1/0/0", bus.state, bus.shift_dr, bus.tdo);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        bus.dr_tdo = 1'b0;
    endtask

    task automatic test_ir_load;
        logic [3:0] exp_tdo;
        exp_tdo = 4'b0001;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h4) begin
            failures++;
            $display("FAIL ir_selir got=%h exp=4", bus.state);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'hE || bus.capture_ir !== 1'b1) begin
            failures++;
            $display("FAIL ir_capir got=%h/%b exp=e/1", bus.state, bus.capture_ir);
        end
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.tdo !== exp_tdo[i] || bus.tdo_en !== 1'b1 || bus.shift_ir !== 1'b1) begin
                failures++;
                $display("FAIL ir_tdo%0d got=%b/%b exp=%b/1", i, bus.tdo, bus.tdo_en, exp_tdo[i]);
            end
            step(i == 3, 1'b0);
        end
        checks++;
        if (bus.state !== 4'h9) begin
            failures++;
            $display("FAIL ir_ex1ir got=%h exp=9", bus.state);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'hD || bus.update_ir !== 1'b1 ||
            bus.instr !== 4'b0001 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL ir_updir got=%h/%b/%b/%b exp=d/1/0001/0",
                     bus.state, bus.update_ir, bus.instr, bus.mode);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.instr !== 4'b0000 || bus.mode !== 1'b1 || bus.bypass_sel !== 1'b0) begin
            failures++;
            $display("FAIL ir_extest got=%b/%b/%b exp=0000/1/0", bus.instr, bus.mode, bus.bypass_sel);
        end
    endtask

    task automatic test_forced_reset;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h4 || bus.test_logic_reset !== 1'b0 || bus.mode !== 1'b1) begin
            failures++;
            $display("FAIL frst_4edges got=%h/%b/%b exp=4/0/1", bus.state, bus.test_logic_reset, bus.mode);
        end
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'hF || bus.test_logic_reset !== 1'b1 ||
            bus.instr !== 4'b0001 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL frst_tlr got=%h/%b/%b/%b exp=f/1/0001/0",
                     bus.state, bus.test_logic_reset, bus.instr, bus.mode);
        end
        step(1'b0, 1'b0);
    endtask

    task automatic test_pause_resume;
        int s0;
        int u0;
        s0 = sdr_cnt;
        u0 = udr_cnt;
        bus.dr_tdo = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'h3 || bus.shift_dr !== 1'b0 || bus.tdo !== 1'b0) begin
            failures++;
            $display("FAIL pause_enter got=%h/%b/%b exp=3/0/0", bus.state, bus.shift_dr, bus.tdo);
        end
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h0 || bus.shift_dr !== 1'b0) begin
            failures++;
            $display("FAIL pause_ex2 got=%h/%b exp=0/0", bus.state, bus.shift_dr);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.state !== 4'h2 || bus.shift_dr !== 1'b1 || bus.tdo !== 1'b1) begin
            failures++;
            $display("FAIL pause_resume got=%h/%b/%b exp=2/1/1", bus.state, bus.shift_dr, bus.tdo);
        end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (bus.state !== 4'h5 || bus.update_dr !== 1'b1) begin
            failures++;
            $display("FAIL pause_upddr got=%h/%b exp=5/1", bus.state, bus.update_dr);
        end
        step(1'b0, 1'b0);
        checks++;
        if (bus.update_dr !== 1'b0 || udr_cnt - u0 !== 1) begin
            failures++;
            $display("FAIL pause_upd_pulse got=%b/%0d exp=0/1", bus.update_dr, udr_cnt - u0);
        end
        checks++;
        if (sdr_cnt - s0 !== 3) begin
            failures++;
            $display("FAIL pause_shift_cnt got=%0d exp=3", sdr_cnt - s0);
        end
        bus.dr_tdo = 1'b0;
    endtask

    task automatic test_undefined;
        load_ir(4'b0101);
        checks++;
        if (bus.instr !== 4'b0101 || bus.bypass_sel !== 1'b1 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL undef_0101 got=%b/%b/%b exp=0101/1/0", bus.instr, bus.bypass_sel, bus.mode);
        end
        load_ir(4'b1111);
        checks++;
        if (bus.instr !== 4'b1111 || bus.bypass_sel !== 1'b1 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL undef_1111 got=%b/%b/%b exp=1111/1/0", bus.instr, bus.bypass_sel, bus.mode);
        end
        load_ir(4'b0010);
        checks++;
        if (bus.instr !== 4'b0010 || bus.bypass_sel !== 1'b0 || bus.mode !== 1'b0) begin
            failures++;
            $display("FAIL undef_sample got=%b/%b/%b exp=0010/0/0", bus.instr, bus.bypass_sel, bus.mode);
        end
    endtask

    task automatic test_reset_abort;
        load_ir(4'b0000);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.state !== 4'hF || bus.instr !== 4'b0001 || bus.mode !== 1'b0 ||
            bus.tdo_en !== 1'b0 || bus.tdo !== 1'b0) begin
            failures++;
            $display("FAIL abort got=%h/%b/%b/%b/%b exp=f/0001/0/0/0",
                     bus.state, bus.instr, bus.mode, bus.tdo_en, bus.tdo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        bus.tms    = 1'b1;
        bus.tdi    = 1'b0;
        bus.dr_tdo = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        test_reset;
        test_state_walk;
        test_ir_load;
        test_forced_reset;
        test_pause_resume;
        test_undefined;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
